leaf_config_ctrl: RTL

//  Configuration sequencer for one leaf's stream flow-control interface. Snoops the leaf's incoming

---
 rtl/leaf_config_ctrl_if.sv | 34 +++
 rtl/leaf_config_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/leaf_config_ctrl_if.sv
// Signal bundle between a leaf's packet stream / host and its configuration sequencer.
// The master drives the stream, leaf address and start request; the slave returns configuration status.
interface leaf_config_ctrl_if #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7
);
    localparam int OUT_PORTS_REG_BITS = NUM_LEAF_BITS + NUM_PORT_BITS + 2 * NUM_ADDR_BITS + 3;
    localparam int IN_PORTS_REG_BITS  = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int REG_CONTROL_BITS   = OUT_PORTS_REG_BITS * NUM_OUT_PORTS + IN_PORTS_REG_BITS * NUM_IN_PORTS;

    logic [NUM_LEAF_BITS-1:0]    self_leaf;
    logic [PACKET_BITS-1:0]      stream_in;
    logic                        ap_start;
    logic [REG_CONTROL_BITS-1:0] control_reg;
    logic                        ap_start_out;
    logic [1:0]                  cfg_state;
    logic                        cfg_ack;
    logic                        cfg_err;
    logic [7:0]                  cfg_wr_count;

    modport master (
        output self_leaf, stream_in, ap_start,
        input  control_reg, ap_start_out, cfg_state, cfg_ack, cfg_err, cfg_wr_count
    );

    modport slave (
        input  self_leaf, stream_in, ap_start,
        output control_reg, ap_start_out, cfg_state, cfg_ack, cfg_err, cfg_wr_count
    );
endinterface

// File: rtl/leaf_config_ctrl.sv
// Snoops a leaf's packet stream for configuration packets, builds a shadow routing register,
// commits it atomically to control_reg and holds ap_start off until a configuration is live.
module leaf_config_ctrl #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PAYLOAD_BITS  = 64,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int CFG_PORT      = 0
) (
    input  logic               clk,
    input  logic               reset,
    leaf_config_ctrl_if.slave  bus
);
    localparam int OUT_PORTS_REG_BITS = NUM_LEAF_BITS + NUM_PORT_BITS + 2 * NUM_ADDR_BITS + 3;
    localparam int IN_PORTS_REG_BITS  = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int REG_CONTROL_BITS   = OUT_PORTS_REG_BITS * NUM_OUT_PORTS + IN_PORTS_REG_BITS * NUM_IN_PORTS;
    localparam int OUT_BASE           = IN_PORTS_REG_BITS * NUM_IN_PORTS;

    localparam logic [3:0] OP_WR_IN  = 4'd1;
    localparam logic [3:0] OP_WR_OUT = 4'd2;
    localparam logic [3:0] OP_COMMIT = 4'd3;
    localparam logic [3:0] OP_CLEAR  = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RUN    = 2'd3
    } cfg_state_t;

    cfg_state_t                  state;
    cfg_state_t                  state_next;
    logic [REG_CONTROL_BITS-1:0] shadow;
    logic [REG_CONTROL_BITS-1:0] control_reg;
    logic                        cfg_ack;
    logic                        cfg_err;
    logic [7:0]                  wr_count;

    logic                          pkt_valid;
    logic [NUM_LEAF_BITS-1:0]      pkt_leaf;
    logic [NUM_PORT_BITS-1:0]      pkt_port;
    logic [PAYLOAD_BITS-1:0]       payload;
    logic [3:0]                    opcode;
    logic [NUM_PORT_BITS-1:0]      idx;
    logic [OUT_PORTS_REG_BITS-1:0] val;
    logic                          is_cfg;
    logic                          wr_in_ok;
    logic                          wr_out_ok;
    logic                          op_commit;
    logic                          op_clear;
    logic                          accept;
    logic                          unused_bits;

    assign pkt_valid = bus.stream_in[PACKET_BITS-1];
    assign pkt_leaf  = bus.stream_in[PACKET_BITS-2 -: NUM_LEAF_BITS];
    assign pkt_port  = bus.stream_in[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign payload   = bus.stream_in[PAYLOAD_BITS-1:0];
    assign opcode    = payload[PAYLOAD_BITS-1 -: 4];
    assign idx       = payload[PAYLOAD_BITS-5 -: NUM_PORT_BITS];
    assign val       = payload[OUT_PORTS_REG_BITS-1:0];

    assign unused_bits = ^{bus.stream_in[PACKET_BITS-2-NUM_LEAF_BITS-NUM_PORT_BITS : PAYLOAD_BITS],
                           payload[PAYLOAD_BITS-5-NUM_PORT_BITS : OUT_PORTS_REG_BITS]};

    // Only packets addressed to this leaf's reserved port are configuration traffic.
    assign is_cfg    = pkt_valid && (pkt_leaf == bus.self_leaf) && (pkt_port == NUM_PORT_BITS'(CFG_PORT));
    assign wr_in_ok  = is_cfg && (opcode == OP_WR_IN)  && (idx < NUM_PORT_BITS'(NUM_IN_PORTS));
    assign wr_out_ok = is_cfg && (opcode == OP_WR_OUT) && (idx < NUM_PORT_BITS'(NUM_OUT_PORTS));
    assign op_commit = is_cfg && (opcode == OP_COMMIT);
    assign op_clear  = is_cfg && (opcode == OP_CLEAR);
    assign accept    = wr_in_ok || wr_out_ok || op_commit || op_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_COMMIT) begin
            state_next = ST_RUN;
        end
        if (op_clear) begin
            state_next = ST_IDLE;
        end else if (op_commit) begin
            state_next = ST_COMMIT;
        end else if ((wr_in_ok || wr_out_ok) && (state == ST_IDLE)) begin
            state_next = ST_LOAD;
        end
    end

    // The commit copy samples shadow before a same-cycle write lands; CLEAR overrides both.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            control_reg <= '0;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
            wr_count    <= 8'd0;
        end else begin
            cfg_ack <= accept;
            cfg_err <= is_cfg && !accept;
            if (state == ST_COMMIT) begin
                control_reg <= shadow;
            end
            if (op_clear) begin
                shadow      <= '0;
                control_reg <= '0;
                wr_count    <= 8'd0;
            end else begin
                for (int i = 0; i < NUM_IN_PORTS; i++) begin
                    if (wr_in_ok && (idx == NUM_PORT_BITS'(i))) begin
                        shadow[i*IN_PORTS_REG_BITS +: IN_PORTS_REG_BITS] <= val[IN_PORTS_REG_BITS-1:0];
                    end
                end
                for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                    if (wr_out_ok && (idx == NUM_PORT_BITS'(i))) begin
                        shadow[OUT_BASE + i*OUT_PORTS_REG_BITS +: OUT_PORTS_REG_BITS] <= val;
                    end
                end
                if ((wr_in_ok || wr_out_ok) && (wr_count != 8'hFF)) begin
                    wr_count <= wr_count + 8'd1;
                end
            end
        end
    end

    assign bus.control_reg  = control_reg;
    assign bus.cfg_state    = state;
    assign bus.cfg_ack      = cfg_ack;
    assign bus.cfg_err      = cfg_err;
    assign bus.cfg_wr_count = wr_count;
    assign bus.ap_start_out = bus.ap_start && (state == ST_RUN);
endmodule
